// File: rtl/odo_sbox_seq.sv
// rtl/odo_sbox_seq.sv - time-shares one 6-bit S-box over a CHUNKS x 6-bit word.
// Optional abort input under `ifdef ODO_SBOX_SEQ_ABORT_EN.
module odo_sbox_seq #(
  parameter int CHUNKS   = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef ODO_SBOX_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [6*CHUNKS-1:0] data_in,
  output logic [5:0]          sbox_in,
  input  logic [5:0]          sbox_out,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [6*CHUNKS-1:0] data_out,
  output logic                busy
);

  localparam int W  = 6 * CHUNKS;
  localparam int CW = $clog2(CHUNKS) + 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    word_q;
  logic [CW-1:0]   issue_cnt;
  logic [SBOX_LAT:0] pipe_vld;
  logic [CW-1:0]   pipe_idx [SBOX_LAT+1];
  logic            ready_q;
  logic            hold_q;
  logic            abort_hit;
  logic            accept;
  logic            push_vld;
  logic [CW-1:0]   push_idx;
  logic            last_cap;
  logic [5:0]      next_chunk;

`ifdef ODO_SBOX_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);

  // start_ready is masked for one idle cycle after an abort so stale S-box data drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
  assign hold_q    = 1'b0;
`endif

  assign start_ready = ready_q && !hold_q;
  assign accept      = start_valid && start_ready && (state == IDLE);
  assign push_vld    = accept || (state == FEED);
  assign push_idx    = (state == FEED) ? issue_cnt : '0;
  assign last_cap    = pipe_vld[SBOX_LAT] && (pipe_idx[SBOX_LAT] == CW'(CHUNKS - 1));

  always_comb begin
    next_chunk = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (issue_cnt == CW'(k)) next_chunk = word_q[6*k +: 6];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_q       <= '0;
      issue_cnt    <= '0;
      pipe_vld     <= '0;
      for (int k = 0; k <= SBOX_LAT; k++) pipe_idx[k] <= '0;
      ready_q      <= 1'b1;
      busy         <= 1'b0;
      sbox_in      <= '0;
      result_valid <= 1'b0;
      data_out     <= '0;
    end else begin
      // Capture runs regardless of state so FEED and DRAIN overlap.
      pipe_vld    <= {pipe_vld[SBOX_LAT-1:0], push_vld};
      pipe_idx[0] <= push_idx;
      for (int k = 1; k <= SBOX_LAT; k++) pipe_idx[k] <= pipe_idx[k-1];

      if (abort_hit) begin
        state        <= IDLE;
        pipe_vld     <= '0;
        issue_cnt    <= '0;
        result_valid <= 1'b0;
        busy         <= 1'b0;
        ready_q      <= 1'b1;
      end else begin
        if (pipe_vld[SBOX_LAT]) begin
          for (int k = 0; k < CHUNKS; k++) begin
            if (pipe_idx[SBOX_LAT] == CW'(k)) data_out[6*k +: 6] <= sbox_out;
          end
        end
        case (state)
          IDLE: begin
            if (accept) begin
              word_q    <= data_in;
              sbox_in   <= data_in[5:0];
              issue_cnt <= CW'(1);
              ready_q   <= 1'b0;
              busy      <= 1'b1;
              state     <= FEED;
            end
          end
          FEED: begin
            sbox_in   <= next_chunk;
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == CW'(CHUNKS - 1)) state <= DRAIN;
          end
          DRAIN: begin
            if (last_cap) begin
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
          DONE: begin
            if (result_ready) begin
              result_valid <= 1'b0;
              busy         <= 1'b0;
              ready_q      <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_odo_sbox_seq.sv
// tb/tb_odo_sbox_seq.sv - randomized bench for odo_sbox_seq against a table-lookup model.
module tb_odo_sbox_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv, rr;
  logic [59:0] din;
  int          cur;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [5:0]  lut [64];

  logic        sv_a, sv_b, rr_a, rr_b;
  logic        sr_a, sr_b, rv_a, rv_b, bsy_a, bsy_b;
  logic [5:0]  sbi_a, sbi_b, sbo_a, sbo_b;
  logic [59:0] dout_a;
  logic [23:0] dout_b;
  logic [5:0]  rb1, rb2, rb3;
  logic        rv, sr, bsy;
  logic [5:0]  sbi;
  logic [59:0] dout;
`ifdef ODO_SBOX_SEQ_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) lut[i] = 6'((i * 37 + 3) & 63);
    lut[1]  = 6'h23;
    lut[63] = 6'h0C;
  end

  odo_sbox_seq #(.CHUNKS(10), .SBOX_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef ODO_SBOX_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start_valid(sv_a), .start_ready(sr_a), .data_in(din),
    .sbox_in(sbi_a), .sbox_out(sbo_a), .result_valid(rv_a),
    .result_ready(rr_a), .data_out(dout_a), .busy(bsy_a));

  odo_sbox_seq #(.CHUNKS(4), .SBOX_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef ODO_SBOX_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start_valid(sv_b), .start_ready(sr_b), .data_in(din[23:0]),
    .sbox_in(sbi_b), .sbox_out(sbo_b), .result_valid(rv_b),
    .result_ready(rr_b), .data_out(dout_b), .busy(bsy_b));

  always @(posedge clk) sbo_a <= lut[sbi_a];

  always @(posedge clk) begin
    rb1 <= lut[sbi_b];
    rb2 <= rb1;
    rb3 <= rb2;
  end
  assign sbo_b = rb3;

  always_comb begin
    sv_a = sv && (cur == 0);
    sv_b = sv && (cur == 1);
    rr_a = rr && (cur == 0);
    rr_b = rr && (cur == 1);
    if (cur == 1) begin
      rv = rv_b; sr = sr_b; bsy = bsy_b; sbi = sbi_b; dout = {36'b0, dout_b};
    end else begin
      rv = rv_a; sr = sr_a; bsy = bsy_a; sbi = sbi_a; dout = dout_a;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] model(input int n, input logic [59:0] d);
    logic [59:0] r = '0;
    for (int i = 0; i < n; i++) r[6*i +: 6] = lut[d[6*i +: 6]];
    return r;
  endfunction

  function automatic logic [59:0] rand_word(input int n);
    logic [63:0] t = {$urandom(), $urandom()};
    logic [59:0] m = '0;
    for (int i = 0; i < 6 * n; i++) m[i] = 1'b1;
    return t[59:0] & m;
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic run_word(input int inst, input logic [59:0] d, input int hold, input bit early);
    int n, lat, edges;
    logic [59:0] exp;
    n   = (inst == 1) ? 4 : 10;
    lat = (inst == 1) ? 3 : 1;
    exp = model(n, d);
    cur = inst;
    din = d;
    sv  = 1'b1;
    #1 check("start_ready_idle", 64'(sr), 64'(1));
    @(negedge clk);
    sv = 1'b0;
    rr = early;
    check("sbox_in_chunk0", 64'(sbi), 64'(d[5:0]));
    check("busy_running", 64'(bsy), 64'(1));
    edges = 0;
    while (!rv && edges < 200) begin
      @(negedge clk);
      edges++;
      if (edges < n) check("sbox_in_seq", 64'(sbi), 64'(d[6*edges +: 6]));
    end
    check("latency", 64'(edges), 64'(n + lat));
    check("data_out", 64'(dout), 64'(exp));
    check("start_ready_done", 64'(sr), 64'(0));
    if (hold > 0) begin
      sv  = 1'b1;
      din = ~d;
      repeat (hold) @(negedge clk);
      check("hold_data", 64'(dout), 64'(exp));
      check("hold_valid", 64'(rv), 64'(1));
      check("hold_sbox", 64'(sbi), 64'(d[6*(n-1) +: 6]));
      check("hold_ready", 64'(sr), 64'(0));
    end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    check("post_valid", 64'(rv), 64'(0));
    check("post_ready", 64'(sr), 64'(1));
    check("post_busy", 64'(bsy), 64'(0));
  endtask

  initial begin
    logic [59:0] d;
    bit seen;
    rst_n = 1'b0; sv = 1'b0; rr = 1'b0; din = '0; cur = 0;
`ifdef ODO_SBOX_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(sr), 64'(1));
    check("rst_valid", 64'(rv), 64'(0));
    check("rst_busy", 64'(bsy), 64'(0));
    check("rst_sbox_in", 64'(sbi), 64'(0));
    check("rst_data_out", 64'(dout), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_word(0, 60'h0, 0, 1'b0);
    run_word(0, 60'hFC1, 0, 1'b0);
    run_word(0, rand_word(10), 20, 1'b0);
    run_word(0, rand_word(10), 0, 1'b1);

    // Reset asserted mid-FEED clears everything asynchronously.
    din = rand_word(10);
    sv  = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(sr), 64'(1));
    check("midrst_valid", 64'(rv), 64'(0));
    check("midrst_busy", 64'(bsy), 64'(0));
    check("midrst_sbox_in", 64'(sbi), 64'(0));
    check("midrst_data_out", 64'(dout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_ready", 64'(sr), 64'(1));
    check("after_rst_valid", 64'(rv), 64'(0));
    run_word(0, rand_word(10), 0, 1'b0);

    for (int i = 0; i < 4; i++) run_word(1, rand_word(4), (i == 0) ? 5 : 0, i[0]);

`ifdef ODO_SBOX_SEQ_ABORT_EN
    cur = 0;
    din = rand_word(10);
    sv  = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(bsy), 64'(0));
    check("abort_valid", 64'(rv), 64'(0));
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rv) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'(0));
    run_word(0, rand_word(10), 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/odo_sbox_seq.md
Name: odo_sbox_seq

Overview:
- Sequencer that pushes a wide word through one shared 6-bit odo_sbox_small* lookup instance, one 6-bit chunk per clock.
- Reassembles the substituted chunks into an output word.
- Sits between the round datapath and a single registered S-box ROM, replacing CHUNKS parallel ROM copies with one time-shared instance.
- Valid/ready handshake on both the input and the output side.

Parameters:
- CHUNKS, 10, number of 6-bit chunks per word; word width is 6*CHUNKS; legal range 2..64.
- SBOX_LAT, 1, read latency in clocks of the attached S-box (registered ROM = 1); legal range 1..4.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  data_in valid.
- start_ready  output  1  block can accept a word.
- data_in  input  6*CHUNKS  word to substitute; chunk k = bits [6k+5:6k].
- sbox_in  output  6  address to the shared S-box (registered).
- sbox_out  input  6  S-box data, valid SBOX_LAT clocks after the sbox_in edge.
- result_valid  output  1  data_out holds a complete substituted word.
- result_ready  input  1  consumer takes data_out.
- data_out  output  6*CHUNKS  substituted word; chunk k = S(data_in chunk k).
- busy  output  1  high in FEED, DRAIN and DONE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, start_ready=1, result_valid=0, busy=0, sbox_in=0, data_out=0, all counters 0.
- rst_n low mid-operation aborts immediately. Partial results are discarded, and the first post-reset result is a fresh word.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready at edge E0: latch data_in, set sbox_in<=chunk 0, issue_cnt<=1, go to FEED, start_ready<=0, busy<=1.
- FEED:
  - Each edge drives sbox_in<=chunk issue_cnt and increments issue_cnt.
  - After chunk CHUNKS-1 is driven, go to DRAIN.
  - sbox_in holds its last value outside FEED.
- Capture:
  - A SBOX_LAT+1 deep valid/index shift register tracks issued chunks.
  - Chunk i is on sbox_in after E(i) and is captured from sbox_out at E(i+1+SBOX_LAT) into data_out chunk i.
  - Capture is independent of state, so FEED and DRAIN overlap.
- DRAIN: wait until the last chunk is captured; at that edge go to DONE and result_valid<=1.
- Latency: result_valid rises exactly CHUNKS+SBOX_LAT edges after the accept edge (11 with defaults). Throughput is one chunk per clock.
- DONE:
  - result_valid and data_out hold stable until result_valid&&result_ready.
  - At that edge: result_valid<=0, busy<=0, start_ready<=1, go to IDLE.
  - start_valid is ignored while start_ready=0 (no overlap between words).
- Back-pressure: result_ready may stay low indefinitely. Nothing is lost, and the S-box is not driven while held.
- result_ready high before result_valid has no effect.
- data_out chunks not yet captured in the current word keep their previous-word values. Only a complete word is qualified by result_valid.
- Index arithmetic: issue_cnt and capture index are clog2(CHUNKS)+1 bits wide and never wrap within a word.

Optional Feature:
- Macro ODO_SBOX_SEQ_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit).
  - abort high at an edge in FEED, DRAIN or DONE forces IDLE, clears the capture pipeline valids, result_valid<=0, busy<=0, start_ready<=1. data_out keeps its contents.
  - abort in IDLE has no effect.
  - abort has priority over accept and handshake at the same edge.
  - The first accept after an abort waits one idle cycle so in-flight S-box data is not captured.
- Without the macro: no abort port; a word always runs to completion.

Test Plan:
- Reset defaults: assert rst_n=0 mid-FEED → outputs immediately reset as listed; after release start_ready=1 and result_valid=0.
- Zero word: defaults with odo_sbox_small11 attached, data_in=0, start_valid one cycle → result_valid exactly 11 edges after accept; every data_out chunk = 6'h03.
- Mixed chunks: chunk0=6'h01, chunk1=6'h3F, rest 6'h00 → data_out chunk0=6'h23, chunk1=6'h0C, rest 6'h03; sbox_in sequence 01,3F,00… on consecutive edges.
- Back-pressure: hold result_ready=0 for 20 cycles with start_valid held high and a new data_in → data_out stable, start_ready=0, sbox_in unchanged; release → second word accepted the edge after the handshake.
- Latency sweep: SBOX_LAT=3 with a 3-stage ROM model, CHUNKS=4 → result_valid 7 edges after accept; chunks in correct order.
- Abort (ODO_SBOX_SEQ_ABORT_EN): abort at issue_cnt=5 → IDLE next edge, result_valid never asserted; the next word completes with correct substituted values.
